// File: rtl/remodel_sram_streamer_if.sv
// remodel_sram_streamer_if: control, SRAM initiator and stream signals of the streamer
interface remodel_sram_streamer_if #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 128,
    parameter int ByteWidth = 8
);
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int LenWidth  = AddrWidth + 1;
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;

    logic                 start_i;
    logic                 mode_i;
    logic [AddrWidth-1:0] base_i;
    logic [LenWidth-1:0]  len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 sram_req_o;
    logic                 sram_we_o;
    logic [AddrWidth-1:0] sram_addr_o;
    logic [DataWidth-1:0] sram_wdata_o;
    logic [BeWidth-1:0]   sram_be_o;
    logic [DataWidth-1:0] sram_rdata_i;
    logic [DataWidth-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic [DataWidth-1:0] wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;

    modport slave (
        input  start_i, mode_i, base_i, len_i, sram_rdata_i, rd_ready_i, wr_data_i, wr_valid_i,
        output busy_o, done_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
               rd_data_o, rd_valid_o, wr_ready_o
    );

    modport master (
        output start_i, mode_i, base_i, len_i, sram_rdata_i, rd_ready_i, wr_data_i, wr_valid_i,
        input  busy_o, done_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
               rd_data_o, rd_valid_o, wr_ready_o
    );
endinterface

// File: rtl/remodel_sram_streamer.sv
// remodel_sram_streamer: moves a block of SRAM words to a read stream or from a write stream
module remodel_sram_streamer #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 128,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int FifoDepth = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    remodel_sram_streamer_if.slave  bus
);
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int LenWidth  = AddrWidth + 1;
    localparam int PtrWidth  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntWidth  = $clog2(FifoDepth + 1);
    localparam int SumWidth  = $clog2(FifoDepth + Latency + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_mode;
    logic [AddrWidth-1:0] r_base;
    logic [LenWidth-1:0]  r_len, r_issued;
    logic [Latency-1:0]   r_infl;
    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [PtrWidth-1:0]  r_wp, r_rp;
    logic [CntWidth-1:0]  r_cnt;
    logic                 w_run, w_room, w_rd_issue, w_wr_issue, w_push, w_pop;
    logic [SumWidth-1:0]  w_used;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = !bus.start_i ? IDLE : (bus.len_i == '0) ? DONE : RUN;
            RUN:     w_state_nxt = (r_issued != r_len) ? RUN : r_mode ? DONE : DRAIN;
            DRAIN:   w_state_nxt = (r_infl == '0 && r_cnt == CntWidth'(w_pop)) ? DONE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so back-to-back reads keep flowing at FifoDepth = Latency+1
    always_comb begin
        w_run             = r_state == RUN;
        w_room            = r_issued < r_len;
        w_push            = r_infl[Latency-1];
        w_pop             = (r_cnt != '0) && bus.rd_ready_i;
        w_used            = SumWidth'(r_cnt) + SumWidth'($countones(r_infl)) - SumWidth'(w_pop);
        w_rd_issue        = w_run && !r_mode && w_room && (w_used < SumWidth'(FifoDepth));
        w_wr_issue        = w_run && r_mode && w_room && bus.wr_valid_i;
        bus.busy_o        = r_state != IDLE;
        bus.done_o        = r_state == DONE;
        bus.wr_ready_o    = w_run && r_mode && w_room;
        bus.sram_req_o    = w_rd_issue || w_wr_issue;
        bus.sram_we_o     = w_wr_issue;
        bus.sram_addr_o   = r_base + r_issued[AddrWidth-1:0];
        bus.sram_wdata_o  = w_wr_issue ? bus.wr_data_i : '0;
        bus.sram_be_o     = w_wr_issue ? '1 : '0;
        bus.rd_valid_o    = r_cnt != '0;
        bus.rd_data_o     = r_mem[r_rp];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode   <= 1'b0;
            r_base   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_infl   <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == IDLE && bus.start_i) begin
                r_mode   <= bus.mode_i;
                r_base   <= bus.base_i;
                r_len    <= bus.len_i;
                r_issued <= '0;
            end else if (bus.sram_req_o) begin
                r_issued <= r_issued + LenWidth'(1);
            end
            r_infl <= Latency'({r_infl, w_rd_issue});
            if (w_push) r_wp <= (r_wp == PtrWidth'(FifoDepth - 1)) ? '0 : r_wp + PtrWidth'(1);
            if (w_pop) r_rp <= (r_rp == PtrWidth'(FifoDepth - 1)) ? '0 : r_rp + PtrWidth'(1);
            r_cnt <= r_cnt + CntWidth'(w_push) - CntWidth'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= bus.sram_rdata_i;
    end
endmodule
